// File: rtl/uart_byte_sequencer.sv
// uart_byte_sequencer: walks the 3-bit byte-mux select from 7 downward and handshakes
// each selected byte with the UART TX core, producing one burst per start request.
module uart_byte_sequencer #(
    parameter int NUM_BYTES = 8,
    parameter int BYTE_GAP  = 0,
    parameter int TIMEOUT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       tx_done,
    output logic [2:0] select,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       timeout
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, GAP, FIN} state_t;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [7:0] G_LAST = 8'(BYTE_GAP > 0 ? BYTE_GAP - 1 : 0);
    localparam logic [2:0] B_LAST = 3'(NUM_BYTES - 1);
    state_t state_q, state_d;
    logic [2:0] select_q, select_d, cnt_q, cnt_d;
    logic [TW-1:0] wait_q, wait_d;
    logic [7:0] gap_q, gap_d;
    logic tx_start_q, busy_q, done_q, timeout_q, timeout_d;
    assign select   = select_q;
    assign tx_start = tx_start_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    // The wait counter also counts the SEND cycle, so expiry lands TIMEOUT cycles after tx_start.
    always_comb begin
        state_d   = state_q;
        select_d  = select_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        if (abort && state_q != IDLE) begin
            state_d  = IDLE;
            select_d = 3'b111;
            cnt_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    select_d = 3'b111;
                    cnt_d    = '0;
                    if (start && !abort) state_d = LOAD;
                end
                LOAD: begin
                    wait_d  = '0;
                    state_d = SEND;
                end
                SEND: begin
                    wait_d  = wait_q + TW'(1);
                    state_d = WAIT;
                end
                WAIT: begin
                    wait_d = wait_q + TW'(1);
                    if (tx_done) begin
                        if (cnt_q == B_LAST) begin
                            state_d = FIN;
                        end else begin
                            select_d = select_q - 3'd1;
                            cnt_d    = cnt_q + 3'd1;
                            gap_d    = '0;
                            state_d  = BYTE_GAP > 0 ? GAP : LOAD;
                        end
                    end else if (TIMEOUT > 0 && (wait_q == T_LAST || TIMEOUT == 1)) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                        select_d  = 3'b111;
                        cnt_d     = '0;
                    end
                end
                GAP: begin
                    gap_d   = gap_q + 8'd1;
                    state_d = gap_q == G_LAST ? LOAD : GAP;
                end
                default: begin
                    state_d  = IDLE;
                    select_d = 3'b111;
                    cnt_d    = '0;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            select_q   <= 3'b111;
            cnt_q      <= '0;
            wait_q     <= '0;
            gap_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            select_q   <= select_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
            gap_q      <= gap_d;
            tx_start_q <= state_d == SEND;
            busy_q     <= state_d != IDLE;
            done_q     <= state_d == FIN;
            timeout_q  <= timeout_d;
        end
    end
endmodule

// File: tb/tb_uart_byte_sequencer.sv
// tb_uart_byte_sequencer: directed bursts on two configurations; expected tx_start/done/timeout
// events are queued with hand-computed cycle numbers and checked by a negedge monitor.
module tb_uart_byte_sequencer;
    logic clk = 1'b0, rst_n = 1'b0;
    int cyc = 0, vec = 0, bad = 0;
    logic a_start = 0, a_abort = 0, a_inj = 0, a_mdone = 0, a_en = 1;
    logic b_start = 0, b_abort = 0, b_mdone = 0;
    logic [2:0] a_sel, b_sel;
    logic a_txs, a_busy, a_done, a_to, b_txs, b_busy, b_done, b_to;
    int pa = 0, pb = 0;
    typedef struct {int k; int c; logic [2:0] s;} ev_t;
    ev_t qa[$], qb[$];
    uart_byte_sequencer #(.NUM_BYTES(8), .BYTE_GAP(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort), .tx_done(a_mdone | a_inj),
        .select(a_sel), .tx_start(a_txs), .busy(a_busy), .done(a_done), .timeout(a_to));
    uart_byte_sequencer #(.NUM_BYTES(4), .BYTE_GAP(3), .TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort), .tx_done(b_mdone),
        .select(b_sel), .tx_start(b_txs), .busy(b_busy), .done(b_done), .timeout(b_to));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string n, input int act, input int exp_v);
        vec++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", n, cyc, act, exp_v);
        end
    endtask
    task automatic push(input int d, input int k, input int c, input logic [2:0] s);
        ev_t e;
        e.k = k; e.c = c; e.s = s;
        if (d == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask
    // kind: 0 tx_start, 1 done, 2 timeout
    task automatic sb(input int d, input int k, input logic [2:0] s);
        ev_t e;
        vec++;
        if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
            bad++;
            $display("FAIL unexpected_event dut%0d: got kind %0d at cyc %0d sel %0d, expected none", d, k, cyc, s);
            return;
        end
        if (d == 0) e = qa.pop_front();
        else e = qb.pop_front();
        if (e.k != k || e.c != cyc || e.s != s) begin
            bad++;
            $display("FAIL event dut%0d: got kind %0d cyc %0d sel %0d, expected kind %0d cyc %0d sel %0d",
                     d, k, cyc, s, e.k, e.c, e.s);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (a_txs) sb(0, 0, a_sel);
        if (a_done) sb(0, 1, a_sel);
        if (a_to) sb(0, 2, a_sel);
        if (b_txs) sb(1, 0, b_sel);
        if (b_done) sb(1, 1, b_sel);
        if (b_to) sb(1, 2, b_sel);
    end
    // TX models: tx_done 10 cycles after each observed tx_start
    initial forever begin
        @(posedge clk);
        #1;
        a_mdone = 0;
        b_mdone = 0;
        if (pa > 0) begin pa--; if (pa == 0) a_mdone = 1; end
        if (pb > 0) begin pb--; if (pb == 0) b_mdone = 1; end
        if (a_txs && a_en) pa = 10;
        if (b_txs) pb = 10;
    end
    task automatic check_reset_a(input string n);
        chk({n, "_sel"}, int'(a_sel), 7);
        chk({n, "_txs"}, int'(a_txs), 0);
        chk({n, "_busy"}, int'(a_busy), 0);
        chk({n, "_done"}, int'(a_done), 0);
        chk({n, "_to"}, int'(a_to), 0);
    endtask
    initial begin
        at(2);
        check_reset_a("rst_a");
        chk("rst_b_sel", int'(b_sel), 7);
        chk("rst_b_busy", int'(b_busy), 0);
        at(3);
        rst_n = 1;
        // test 1 + 3: full 8-byte burst, stray start and tx_done must not disturb it
        at(7); a_inj = 1; at(8); a_inj = 0;
        chk("idle_after_inj_busy", int'(a_busy), 0);
        for (int k = 0; k < 8; k++) push(0, 0, 12 + 12 * k, 3'(7 - k));
        push(0, 1, 107, 3'd0);
        at(10); a_start = 1; at(11); a_start = 0;
        chk("t1_busy_load", int'(a_busy), 1);
        chk("t1_sel_load", int'(a_sel), 7);
        at(30); a_start = 1; at(31); a_start = 0;
        at(35); a_inj = 1; at(36); a_inj = 0;
        at(107);
        chk("t1_busy_fin", int'(a_busy), 1);
        at(108);
        chk("t1_busy_after", int'(a_busy), 0);
        chk("t1_sel_after", int'(a_sel), 7);
        // test 4: abort coincides with 3rd tx_done
        for (int k = 0; k < 3; k++) push(0, 0, 122 + 12 * k, 3'(7 - k));
        at(120); a_start = 1; at(121); a_start = 0;
        at(156);
        chk("t4_txdone_seen", int'(a_mdone), 1);
        a_abort = 1; at(157); a_abort = 0;
        chk("t4_busy", int'(a_busy), 0);
        chk("t4_sel", int'(a_sel), 7);
        // test 5: TX goes silent after the first byte's tx_done; 2nd byte times out
        push(0, 0, 172, 3'd7);
        push(0, 0, 184, 3'd6);
        push(0, 2, 200, 3'd7);
        at(170); a_start = 1; at(171); a_start = 0;
        at(175); a_en = 0;
        at(199);
        chk("t5_busy_wait", int'(a_busy), 1);
        at(200);
        chk("t5_busy_to", int'(a_busy), 0);
        at(205); a_en = 1;
        // test 6: async reset in the middle of WAIT, then a full burst
        push(0, 0, 222, 3'd7);
        at(220); a_start = 1; at(221); a_start = 0;
        at(225); #2; rst_n = 0; #1;
        check_reset_a("t6_async");
        at(228); rst_n = 1;
        for (int k = 0; k < 8; k++) push(0, 0, 242 + 12 * k, 3'(7 - k));
        push(0, 1, 337, 3'd0);
        at(240); a_start = 1; at(241); a_start = 0;
        at(338);
        chk("t6_busy_after", int'(a_busy), 0);
        // test 2: 4 bytes with a 3-cycle gap
        for (int k = 0; k < 4; k++) push(1, 0, 352 + 15 * k, 3'(7 - k));
        push(1, 1, 408, 3'd4);
        at(350); b_start = 1; at(351); b_start = 0;
        at(366);
        chk("t2_sel_gap", int'(b_sel), 6);
        chk("t2_busy_gap", int'(b_busy), 1);
        at(409);
        chk("t2_busy_after", int'(b_busy), 0);
        chk("t2_sel_after", int'(b_sel), 7);
        at(420);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
